// File: rtl/gsim_pkg.sv
// gsim_pkg: constants and types shared by the Gauss-Seidel b-loader files.
//   DEPTH       unknowns per frame (solver size)
//   DW          b coefficient width
//   X_W         solver x result width
//   state_t     loader FSM states
//   bank_idx_t  ping-pong bank selector
package gsim_pkg;

    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int X_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RST   = 2'd1,
        BURST = 2'd2,
        WAIT  = 2'd3
    } state_t;

    typedef logic bank_idx_t;

endpackage

// File: rtl/gsim_b_loader_if.sv
// gsim_b_loader_if: host-to-loader valid/ready stream of b coefficients.
//   s_valid  host word valid
//   s_ready  loader can accept a word
//   s_data   b coefficient, element 0 first
//   s_last   final word of a frame
// Modports: master (host side), slave (loader side).
interface gsim_b_loader_if #(
    parameter int DW = gsim_pkg::DW
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/gsim_bank_ram.sv
// gsim_bank_ram: two banks of DEPTH x DW registers for the b ping-pong buffer.
//   clk, reset               clock, synchronous active-high reset (read port only)
//   wr_en/wr_bank/wr_addr/wr_data   fill-side write port
//   rd_en/rd_bank/rd_addr    drain-side read request
//   rd_data                  registered read data, 0 when rd_en was low
module gsim_bank_ram #(
    parameter int DEPTH = gsim_pkg::DEPTH,
    parameter int DW    = gsim_pkg::DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  gsim_pkg::bank_idx_t      wr_bank,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    input  gsim_pkg::bank_idx_t      rd_bank,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data
);
    import gsim_pkg::*;

    logic [DW-1:0] mem_q [2][DEPTH];
    logic [DW-1:0] mem_d [2][DEPTH];
    logic [DW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_bank][wr_addr] = wr_data;
        end
    end

    // Read data is forced to zero when idle so the solver-facing b bus is
    // quiet outside a burst.
    always_comb begin
        rd_data_d = '0;
        if (rd_en) begin
            rd_data_d = mem_q[rd_bank][rd_addr];
        end
    end

    // Storage needs no reset: a bank is only read after it was fully written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/gsim_b_loader.sv
// gsim_b_loader: feeds b coefficient frames from a host stream into the
// Gauss-Seidel solver through a 2-bank ping-pong buffer.
//   clk, reset      clock, synchronous active-high reset
//   s               host stream (gsim_b_loader_if.slave)
//   sol_rst         one-cycle solver reset pulse before each frame
//   in_en, b_in     DEPTH-cycle load burst to the solver
//   sol_out_valid   solver result window, counted in WAIT
//   busy            frame in RST/BURST/WAIT
//   frame_err       one-cycle pulse when a frame is dropped
// Optional: GSIM_B_LOADER_WATCHDOG_EN adds a TIMEOUT_CYC watchdog on WAIT.
//
// state | meaning
// IDLE  | waiting for the drain bank to hold a complete frame
// RST   | sol_rst asserted for one cycle
// BURST | in_en asserted, b_in = drain bank[0..DEPTH-1]
// WAIT  | counting sol_out_valid cycles until the solver has finished
module gsim_b_loader #(
    parameter int DEPTH       = gsim_pkg::DEPTH,
    parameter int DW          = gsim_pkg::DW,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic            clk,
    input  logic            reset,
    gsim_b_loader_if.slave  s,
    output logic            sol_rst,
    output logic            in_en,
    output logic [DW-1:0]   b_in,
    input  logic            sol_out_valid,
    output logic            busy,
    output logic            frame_err
);
    import gsim_pkg::*;

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    state_t          state_q, state_d;
    bank_idx_t       fill_q, fill_d;
    bank_idx_t       drain_q, drain_d;
    logic [1:0]      full_q, full_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sol_rst_q, sol_rst_d;
    logic            in_en_q, in_en_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic            accept;
    logic            last_slot;
    logic            wait_done;
    logic            wd_fire;
    logic            ram_rd_en;
    logic [IW-1:0]   ram_rd_addr;

    assign s.s_ready = ~full_q[fill_q];
    assign accept    = s.s_valid & ~full_q[fill_q];
    assign last_slot = (idx_q == IW'(DEPTH - 1));
    assign wait_done = (state_q == WAIT) && sol_out_valid && (cnt_q == CW'(DEPTH - 1));

`ifdef GSIM_B_LOADER_WATCHDOG_EN
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WW-1:0] wd_q, wd_d;

    // Down-counter preloaded outside WAIT, so it restarts on every WAIT entry;
    // terminal count is reached in the TIMEOUT_CYC-th WAIT cycle.
    always_comb begin
        wd_d = wd_q;
        if (state_q != WAIT) begin
            wd_d = WW'(TIMEOUT_CYC - 1);
        end else if (wd_q != '0) begin
            wd_d = wd_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= WW'(TIMEOUT_CYC - 1);
        end else begin
            wd_q <= wd_d;
        end
    end

    // A normal finish in the same cycle wins over the timeout.
    assign wd_fire = (state_q == WAIT) && (wd_q == '0) && !wait_done;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign wd_fire        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        drain_d     = drain_q;
        full_d      = full_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;

        // Fill side: a frame is kept only if s_last lands exactly on the last slot.
        if (accept) begin
            if (last_slot && s.s_last) begin
                full_d[fill_q] = 1'b1;
                fill_d         = ~fill_q;
                idx_d          = '0;
            end else if (last_slot || s.s_last) begin
                idx_d = '0;
                err_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Drain side. The fill bank can only complete while not full, and the
        // drain bank is full in WAIT, so the two full_d writes never collide.
        case (state_q)
            IDLE: begin
                if (full_q[drain_q]) begin
                    state_d = RST;
                end
            end
            RST: begin
                state_d = BURST;
                cnt_d   = '0;
            end
            BURST: begin
                if (cnt_q == CW'(DEPTH - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (wait_done || wd_fire) begin
                    state_d         = IDLE;
                    full_d[drain_q] = 1'b0;
                    drain_d         = ~drain_q;
                    err_d           = err_d | wd_fire;
                end else if (sol_out_valid) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read one cycle ahead so b_in lines up with the registered in_en.
        ram_rd_en   = (state_d == BURST);
        ram_rd_addr = cnt_d[IW-1:0];

        sol_rst_d = (state_d == RST) || wd_fire;
        in_en_d   = (state_d == BURST);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            fill_q    <= 1'b0;
            drain_q   <= 1'b0;
            full_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            sol_rst_q <= 1'b0;
            in_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            drain_q   <= drain_d;
            full_q    <= full_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sol_rst_q <= sol_rst_d;
            in_en_q   <= in_en_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    gsim_bank_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_bank (fill_q),
        .wr_addr (idx_q),
        .wr_data (s.s_data),
        .rd_en   (ram_rd_en),
        .rd_bank (drain_q),
        .rd_addr (ram_rd_addr),
        .rd_data (b_in)
    );

    assign sol_rst   = sol_rst_q;
    assign in_en     = in_en_q;
    assign busy      = busy_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_gsim_b_loader.sv
// tb_gsim_b_loader: directed self-checking bench for gsim_b_loader.
module tb_gsim_b_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        sol_rst;
    logic        in_en;
    logic [15:0] b_in;
    logic        sol_out_valid;
    logic        busy;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    gsim_b_loader_if #(.DW(16)) bus ();

    gsim_b_loader #(
        .DEPTH       (16),
        .DW          (16),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s             (bus),
        .sol_rst       (sol_rst),
        .in_en         (in_en),
        .b_in          (b_in),
        .sol_out_valid (sol_out_valid),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic last, output int stalls);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (bus.s_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("send_ready_timeout", bus.s_ready, 1);
        step();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        stalls = n;
    endtask

    task automatic send_frame(input logic [15:0] base, input int first, input int n,
                              input bit last_ok, output int stalls);
        int st;
        stalls = 0;
        for (int i = first; i < first + n; i++) begin
            send_word(base + 16'(i), last_ok && (i == first + n - 1), st);
            stalls += st;
        end
    endtask

    task automatic wait_sol_rst();
        int n;
        n = 0;
        while (sol_rst !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("sol_rst_pulse", sol_rst, 1);
    endtask

    // Entered at the cycle where sol_rst is high.
    task automatic do_burst(input logic [15:0] base);
        chk("rst_busy", busy, 1);
        chk("rst_no_in_en", in_en, 0);
        step();
        for (int k = 0; k < 16; k++) begin
            chk("burst_in_en", in_en, 1);
            chk("burst_b_in", b_in, base + 16'(k));
            chk("burst_no_rst", sol_rst, 0);
            step();
        end
        chk("burst_end_in_en", in_en, 0);
        chk("wait_busy", busy, 1);
    endtask

    task automatic retire();
        sol_out_valid = 1'b1;
        repeat (15) step();
        chk("retire_busy_before", busy, 1);
        step();
        sol_out_valid = 1'b0;
        chk("retire_busy_after", busy, 0);
    endtask

    initial begin
        int st;
        int pulses;

        reset         = 1'b1;
        sol_out_valid = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        step();
        step();
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_sol_rst", sol_rst, 0);
        chk("rst_in_en", in_en, 0);
        chk("rst_b_in", b_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        step();

        // Frame 0x0001..0x0010 into bank 0.
        send_frame(16'h0000, 1, 16, 1, st);
        chk("f1_stalls", st, 0);
        chk("f1_no_early_rst", sol_rst, 0);
        step();
        chk("f1_sol_rst", sol_rst, 1);
        do_burst(16'h0001);

`ifdef GSIM_B_LOADER_WATCHDOG_EN
        // No out_valid: timeout fires in the 64th WAIT cycle.
        repeat (63) step();
        chk("wd_pre_rst", sol_rst, 0);
        chk("wd_pre_busy", busy, 1);
        step();
        chk("wd_sol_rst", sol_rst, 1);
        chk("wd_frame_err", frame_err, 1);
        chk("wd_busy", busy, 0);
        step();
        chk("wd_rst_clear", sol_rst, 0);
        chk("wd_err_clear", frame_err, 0);
        chk("wd_idle_busy", busy, 0);
`else
        repeat (1600) step();
        chk("long_wait_busy", busy, 1);
        chk("long_wait_in_en", in_en, 0);
        retire();
        step();
        chk("idle_stays", busy, 0);
`endif

        // Frame A (bank 1), B streamed during A's WAIT, C stalls until A retires.
        send_frame(16'h0100, 0, 16, 1, st);
        wait_sol_rst();
        do_burst(16'h0100);
        send_frame(16'h0200, 0, 16, 1, st);
        chk("b_no_stall", st, 0);
        chk("b_keeps_a_busy", busy, 1);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h0300;
        bus.s_last  = 1'b0;
        chk("c_stall_now", bus.s_ready, 0);
        repeat (4) step();
        chk("c_stall_later", bus.s_ready, 0);
        retire();
        chk("c_ready_after_retire", bus.s_ready, 1);
        step();
        bus.s_valid = 1'b0;
        chk("b_sol_rst", sol_rst, 1);
        do_burst(16'h0200);
        send_frame(16'h0300, 1, 15, 1, st);
        chk("c_rest_stalls", st, 0);
        retire();
        wait_sol_rst();
        do_burst(16'h0300);
        retire();

        // Early s_last on word 5.
        send_frame(16'h0400, 0, 5, 1, st);
        chk("early_last_err", frame_err, 1);
        step();
        chk("early_last_err_clear", frame_err, 0);
        chk("early_last_ready", bus.s_ready, 1);
        // Missing s_last on word 16.
        send_frame(16'h0400, 0, 16, 0, st);
        chk("no_last_err", frame_err, 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sol_rst === 1'b1) pulses++;
        end
        chk("err_no_sol_rst", pulses, 0);
        chk("err_not_busy", busy, 0);
        send_frame(16'h0400, 0, 16, 1, st);
        wait_sol_rst();
        do_burst(16'h0400);
        retire();

        // Reset at burst cycle 7.
        send_frame(16'h0500, 0, 16, 1, st);
        wait_sol_rst();
        step();
        repeat (7) step();
        chk("mid_burst_b_in", b_in, 16'h0507);
        chk("mid_burst_in_en", in_en, 1);
        reset = 1'b1;
        step();
        chk("mid_rst_in_en", in_en, 0);
        chk("mid_rst_s_ready", bus.s_ready, 1);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sol_rst === 1'b1) pulses++;
        end
        chk("mid_rst_no_sol_rst", pulses, 0);
        chk("mid_rst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
